// File: rtl/pipelined_mac_unit.sv
// Pipelined multiply / multiply-accumulate unit with a configurable latency.
// It accepts one operation per cycle and has a wrapping accumulator with a sticky overflow flag.
module pipelined_mac_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ACC_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [1:0]           op,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 valid_out,
    output logic [WIDTH-1:0]     out,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_ovf
);

    localparam int unsigned PW = 2 * WIDTH;
    // Product chain depth: the M register plus LATENCY-2 delay stages.
    localparam int ND = int'(LATENCY) - 1;

    typedef enum logic [1:0] {
        OpMulLo  = 2'b00,
        OpMulHi  = 2'b01,
        OpMac    = 2'b10,
        OpMacClr = 2'b11
    } op_e;

    // Stage 1: operand registers
    logic             r_s1_valid;
    op_e              r_s1_op;
    logic             r_s1_signed;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_op     <= op_e'(op);
        r_s1_signed <= signed_in;
        r_s1_a      <= in0;
        r_s1_b      <= in1;
    end

    logic [PW-1:0] w_a_ext;
    logic [PW-1:0] w_b_ext;
    logic [PW-1:0] w_prod;

    always_comb begin
        w_a_ext = r_s1_signed ? PW'($signed(r_s1_a)) : PW'(r_s1_a);
        w_b_ext = r_s1_signed ? PW'($signed(r_s1_b)) : PW'(r_s1_b);
        w_prod  = w_a_ext * w_b_ext;
    end

    // Stage 2 (index 0) and the remaining delay stages
    logic [ND-1:0] r_p_valid;
    op_e           r_p_op     [ND];
    logic          r_p_signed [ND];
    logic [PW-1:0] r_p_prod   [ND];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_valid <= '0;
        end else begin
            r_p_valid[0] <= r_s1_valid;
            for (int k = 1; k < ND; k++) begin
                r_p_valid[k] <= r_p_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_p_op[0]     <= r_s1_op;
        r_p_signed[0] <= r_s1_signed;
        r_p_prod[0]   <= w_prod;
        for (int k = 1; k < ND; k++) begin
            r_p_op[k]     <= r_p_op[k-1];
            r_p_signed[k] <= r_p_signed[k-1];
            r_p_prod[k]   <= r_p_prod[k-1];
        end
    end

    // Final stage: combinational from the last register
    logic                 w_f_valid;
    op_e                  w_f_op;
    logic                 w_f_signed;
    logic [PW-1:0]        w_f_prod;
    logic [ACC_WIDTH-1:0] w_p_ext;
    logic [ACC_WIDTH:0]   w_sum_full;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_ovf_now;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic                 w_ovf_nxt;

    always_comb begin
        w_f_valid  = r_p_valid[ND-1];
        w_f_op     = r_p_op[ND-1];
        w_f_signed = r_p_signed[ND-1];
        w_f_prod   = r_p_prod[ND-1];
        w_p_ext    = w_f_signed ? ACC_WIDTH'($signed(w_f_prod)) : ACC_WIDTH'(w_f_prod);
        w_sum_full = {1'b0, r_acc} + {1'b0, w_p_ext};
        w_sum      = w_sum_full[ACC_WIDTH-1:0];
        // Signed: same-sign addends with a sign flip; unsigned: carry out.
        if (w_f_signed) begin
            w_ovf_now = (r_acc[ACC_WIDTH-1] == w_p_ext[ACC_WIDTH-1]) &&
                        (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        end else begin
            w_ovf_now = w_sum_full[ACC_WIDTH];
        end
    end

    always_comb begin
        out       = '0;
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (w_f_valid) begin
            unique case (w_f_op)
                OpMulLo: out = w_f_prod[WIDTH-1:0];
                OpMulHi: out = w_f_prod[PW-1:WIDTH];
                OpMac: begin
                    out       = w_sum[WIDTH-1:0];
                    w_acc_nxt = w_sum;
                    w_ovf_nxt = r_ovf | w_ovf_now;
                end
                OpMacClr: begin
                    out       = w_p_ext[WIDTH-1:0];
                    w_acc_nxt = w_p_ext;
                    w_ovf_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign valid_out = w_f_valid;
    assign acc_out   = r_acc;
    assign acc_ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// Self-checking bench: two instances (default config and LATENCY=5/ACC_WIDTH=32) share stimulus.
// A completion-time model checks every cycle; tables and hand sequences check fixed constants.
module tb_pipelined_mac_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [1:0]  op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;

    logic        vo0, vo1, ovf0, ovf1;
    logic [15:0] o0, o1;
    logic [47:0] acc0;
    logic [31:0] acc1;

    always #5 clk = ~clk;

    pipelined_mac_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .signed_in(sgn),
        .in0(a), .in1(b), .valid_out(vo0), .out(o0), .acc_out(acc0), .acc_ovf(ovf0)
    );

    pipelined_mac_unit #(.WIDTH(16), .LATENCY(5), .ACC_WIDTH(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .signed_in(sgn),
        .in0(a), .in1(b), .valid_out(vo1), .out(o1), .acc_out(acc1), .acc_ovf(ovf1)
    );

    typedef struct {
        int          due;
        logic [1:0]  op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
    } ent_t;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eo;
        logic [47:0] eacc;
        logic        eovf;
    } vec_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [15:0] res0[$];
    logic [15:0] res1[$];
    logic [63:0] m_acc [2];
    logic        m_ovf [2];
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    ent_t        pe;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void model_step(input int aw, input ent_t e, input logic [63:0] acc_in,
                                       input logic ovf_in, output logic [15:0] eo,
                                       output logic [63:0] acc_o, output logic ovf_o);
        logic signed [63:0] sa, sb, prod;
        logic [31:0] p;
        logic [63:0] mask, ext, sum, sm;
        logic        s_ovf;
        mask  = (64'd1 << aw) - 64'd1;
        sa    = e.sgn ? 64'($signed(e.a)) : 64'(e.a);
        sb    = e.sgn ? 64'($signed(e.b)) : 64'(e.b);
        prod  = sa * sb;
        p     = prod[31:0];
        ext   = e.sgn ? (64'($signed(p)) & mask) : {32'd0, p};
        sum   = acc_in + ext;
        sm    = sum & mask;
        s_ovf = (acc_in[aw-1] == ext[aw-1]) && (sm[aw-1] != acc_in[aw-1]);
        acc_o = acc_in;
        ovf_o = ovf_in;
        case (e.op)
            2'b00: eo = p[15:0];
            2'b01: eo = p[31:16];
            2'b10: begin
                eo    = sm[15:0];
                acc_o = sm;
                ovf_o = ovf_in | (e.sgn ? s_ovf : sum[aw]);
            end
            default: begin
                eo    = ext[15:0];
                acc_o = ext;
                ovf_o = 1'b0;
            end
        endcase
    endfunction

    // Scoreboard push: stimulus accepted at this edge completes LATENCY-1 edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_acc[0] = '0; m_acc[1] = '0;
            m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        end else if (valid_in) begin
            pe.op = op; pe.sgn = sgn; pe.a = a; pe.b = b;
            pe.due = cyc + 1;
            q0.push_back(pe);
            pe.due = cyc + 4;
            q1.push_back(pe);
        end
    end

    task automatic mon(input int id, input logic vo, input logic [15:0] o,
                       input logic [63:0] acc, input logic ovf);
        ent_t        e;
        logic        have, due_now, no;
        logic [15:0] eo;
        logic [63:0] na;
        have = 1'b0;
        if (id == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (id == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (have && e.due < cyc) begin
            chk($sformatf("dut%0d lost result due %0d", id, e.due), 64'(cyc), 64'(e.due));
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            have = 1'b0;
        end
        due_now = have && (e.due == cyc);
        chk($sformatf("dut%0d valid_out @%0d", id, cyc), 64'(vo), 64'(due_now));
        chk($sformatf("dut%0d acc_out @%0d", id, cyc), acc, m_acc[id]);
        chk($sformatf("dut%0d acc_ovf @%0d", id, cyc), 64'(ovf), 64'(m_ovf[id]));
        if (due_now) begin
            model_step((id == 0) ? 48 : 32, e, m_acc[id], m_ovf[id], eo, na, no);
            chk($sformatf("dut%0d out @%0d", id, cyc), 64'(o), 64'(eo));
            m_acc[id] = na;
            m_ovf[id] = no;
            if (id == 0) begin void'(q0.pop_front()); res0.push_back(o); end
            else begin void'(q1.pop_front()); res1.push_back(o); end
        end else begin
            chk($sformatf("dut%0d idle out @%0d", id, cyc), 64'(o), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, vo0, o0, {16'd0, acc0}, ovf0);
            mon(1, vo1, o1, {32'd0, acc1}, ovf1);
        end
    end

    task automatic issue(input logic [1:0] o, input logic s, input logic [15:0] x,
                         input logic [15:0] y);
        valid_in = 1'b1; op = o; sgn = s; a = x; b = y;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (8) idle();
    endtask

    task automatic pop_res(input int id, input string nm, input logic [15:0] exp);
        chk({nm, " present"}, 64'((id == 0) ? res0.size() : res1.size()) != 0, 64'd1);
        if (id == 0 && res0.size() > 0) chk(nm, 64'(res0.pop_front()), 64'(exp));
        if (id == 1 && res1.size() > 0) chk(nm, 64'(res1.pop_front()), 64'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [12];
        logic [3:0]  pat;
        int          exp_o [4];
        int          nvalid;

        tbl[0]  = '{2'd0, 1'b0, 16'h1234, 16'h0010, 16'h2340, 48'h0, 1'b0};
        tbl[1]  = '{2'd1, 1'b1, 16'hFFFF, 16'h0002, 16'hFFFF, 48'h0, 1'b0};
        tbl[2]  = '{2'd1, 1'b0, 16'hFFFF, 16'h0002, 16'h0001, 48'h0, 1'b0};
        tbl[3]  = '{2'd3, 1'b0, 16'h0003, 16'h0004, 16'h000C, 48'hC, 1'b0};
        tbl[4]  = '{2'd2, 1'b0, 16'h0005, 16'h0006, 16'h002A, 48'h2A, 1'b0};
        tbl[5]  = '{2'd2, 1'b1, 16'hFFFF, 16'hFFFF, 16'h002B, 48'h2B, 1'b0};
        tbl[6]  = '{2'd2, 1'b1, 16'h8000, 16'h0002, 16'h002B, 48'hFFFF_FFFF_002B, 1'b0};
        tbl[7]  = '{2'd0, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA, 48'hFFFF_FFFF_002B, 1'b0};
        tbl[8]  = '{2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 16'h002C, 48'h0000_FFFD_002C, 1'b1};
        tbl[9]  = '{2'd0, 1'b0, 16'h0002, 16'h0003, 16'h0006, 48'h0000_FFFD_002C, 1'b1};
        tbl[10] = '{2'd3, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 48'hFFFF_FFFF_FFFF, 1'b0};
        tbl[11] = '{2'd2, 1'b1, 16'h8000, 16'h8000, 16'hFFFF, 48'h0000_3FFF_FFFF, 1'b0};

        rst_n = 1'b0; valid_in = 1'b0; op = 2'd0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset valid_out0", 64'(vo0), 64'd0);
        chk("reset out0", 64'(o0), 64'd0);
        chk("reset acc0", 64'(acc0), 64'd0);
        chk("reset ovf0", 64'(ovf0), 64'd0);
        chk("reset valid_out1", 64'(vo1), 64'd0);
        chk("reset acc1", 64'(acc1), 64'd0);
        chk("reset ovf1", 64'(ovf1), 64'd0);
        idle();

        for (int i = 0; i < 12; i++) begin
            res0.delete();
            issue(tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b);
            drain();
            pop_res(0, $sformatf("tbl%0d out", i), tbl[i].eo);
            chk($sformatf("tbl%0d acc", i), 64'(acc0), 64'(tbl[i].eacc));
            chk($sformatf("tbl%0d ovf", i), 64'(ovf0), 64'(tbl[i].eovf));
        end

        // Back-to-back MACs see each other's accumulator updates.
        res0.delete(); res1.delete();
        issue(2'd3, 1'b0, 16'd3, 16'd4);
        issue(2'd2, 1'b0, 16'd5, 16'd6);
        issue(2'd2, 1'b1, 16'hFFFF, 16'hFFFF);
        drain();
        pop_res(0, "b2b dut0 out0", 16'd12);
        pop_res(0, "b2b dut0 out1", 16'd42);
        pop_res(0, "b2b dut0 out2", 16'd43);
        pop_res(1, "b2b dut1 out2", 16'd12);
        pop_res(1, "b2b dut1 out1", 16'd42);
        pop_res(1, "b2b dut1 out2", 16'd43);
        chk("b2b acc0", 64'(acc0), 64'd43);
        chk("b2b acc1", 64'(acc1), 64'd43);

        // Unsigned wrap and sticky overflow on the 32-bit accumulator.
        issue(2'd3, 1'b0, 16'hFFFF, 16'hFFFF); drain();
        chk("uovf clr acc1", 64'(acc1), 64'hFFFE_0001);
        issue(2'd2, 1'b0, 16'hFFFF, 16'hFFFF); drain();
        chk("uovf acc1", 64'(acc1), 64'hFFFC_0002);
        chk("uovf ovf1", 64'(ovf1), 64'd1);
        chk("uovf acc0", 64'(acc0), 64'h1_FFFC_0002);
        chk("uovf ovf0", 64'(ovf0), 64'd0);
        issue(2'd2, 1'b0, 16'h0003, 16'h0001); drain();
        chk("uovf sticky acc1", 64'(acc1), 64'hFFFC_0005);
        chk("uovf sticky ovf1", 64'(ovf1), 64'd1);
        issue(2'd3, 1'b0, 16'h0001, 16'h0001); drain();
        chk("uovf clr2 acc1", 64'(acc1), 64'd1);
        chk("uovf clr2 ovf1", 64'(ovf1), 64'd0);

        // Signed overflow: 0x3FFF0001 * 3 crosses 2^31.
        issue(2'd3, 1'b1, 16'h7FFF, 16'h7FFF); drain();
        issue(2'd2, 1'b1, 16'h7FFF, 16'h7FFF); drain();
        chk("sovf pre acc1", 64'(acc1), 64'h7FFE_0002);
        chk("sovf pre ovf1", 64'(ovf1), 64'd0);
        issue(2'd2, 1'b1, 16'h7FFF, 16'h7FFF); drain();
        chk("sovf acc1", 64'(acc1), 64'hBFFD_0003);
        chk("sovf ovf1", 64'(ovf1), 64'd1);
        chk("sovf acc0", 64'(acc0), 64'hBFFD_0003);
        chk("sovf ovf0", 64'(ovf0), 64'd0);

        // LATENCY=5 with a bubble in the issue pattern.
        res1.delete();
        pat = 4'b1101;
        exp_o = '{7, 0, 14, 21};
        issue(2'd0, 1'b0, 16'd1, 16'd7);
        idle();
        issue(2'd0, 1'b0, 16'd2, 16'd7);
        issue(2'd0, 1'b0, 16'd3, 16'd7);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat5 valid[%0d]", k), 64'(vo1), 64'(pat[k]));
            chk($sformatf("lat5 out[%0d]", k), 64'(o1), 64'(exp_o[k]));
        end
        #1;
        drain();

        // Reset one cycle after a MAC is accepted drops it.
        issue(2'd3, 1'b0, 16'd2, 16'd5); drain();
        chk("rst pre acc0", 64'(acc0), 64'd10);
        issue(2'd2, 1'b0, 16'd2, 16'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nvalid += int'(vo0) + int'(vo1);
        end
        chk("rst dropped valids", 64'(nvalid), 64'd0);
        chk("rst acc0", 64'(acc0), 64'd0);
        chk("rst ovf0", 64'(ovf0), 64'd0);
        chk("rst acc1", 64'(acc1), 64'd0);
        @(posedge clk);
        #1;
        res0.delete();
        issue(2'd2, 1'b0, 16'd1, 16'd1); drain();
        pop_res(0, "post rst out", 16'd1);
        chk("post rst acc0", 64'(acc0), 64'd1);

        // Reset at the closing edge of a MAC wins over the accumulator update.
        res0.delete();
        issue(2'd2, 1'b0, 16'd2, 16'd2);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        pop_res(0, "rst final out", 16'd5);
        @(negedge clk);
        chk("rst final acc0", 64'(acc0), 64'd0);
        chk("rst final ovf0", 64'(ovf0), 64'd0);
        #1;
        drain();

        chk("q0 drained", 64'(q0.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_mac_unit.md
Name: pipelined_mac_unit

Overview:
Parametrised pipelined multiply / multiply-accumulate unit: the generalised successor of the fixed 16x16=16, 2-cycle DSP multiplier. Adds:
- configurable operand width and latency;
- selectable low/high product half;
- signed/unsigned operands;
- an internal accumulator with a sticky overflow flag.

It sits in the core datapath beside the ALU and is fed one operation per cycle with no backpressure.

Parameters:
WIDTH, 16, operand and result width in bits; legal range 4..27.
LATENCY, 2, cycles from valid_in to valid_out; legal range 2..6.
ACC_WIDTH, 48, accumulator width; must be >= 2*WIDTH and <= 64.

Ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  synchronous reset, active low
valid_in  in  1  operation present this cycle
op  in  2  00 MUL_LO, 01 MUL_HI, 10 MAC, 11 MAC_CLR
signed_in  in  1  1 = operands two's complement, 0 = unsigned
in0  in  WIDTH  multiplicand
in1  in  WIDTH  multiplier
valid_out  out  1  result present this cycle
out  out  WIDTH  result
acc_out  out  ACC_WIDTH  accumulator register value
acc_ovf  out  1  sticky accumulator overflow flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all valid pipeline bits, accumulator and acc_ovf cleared.
  - valid_out=0, out=0, acc_out=0, acc_ovf=0 from the cycle after the reset edge.
  - Operand and product data registers need no reset.
- Pipeline and latency:
  - Stage 1 registers in0, in1, op and signed_in.
  - Stage 2 registers the full 2*WIDTH product (the M register).
  - LATENCY-2 further delay stages then carry product, op, signed and valid.
  - An operation accepted at edge t (valid_in=1) presents valid_out=1 for exactly one cycle, between edges t+LATENCY-1 and t+LATENCY.
  - The final stage is combinational from the last register to out; there is no extra output register.
- Throughput: one operation per cycle, back-to-back, with no bubbles required.
- Product:
  - signed_in=1: sign-extend both operands to 2*WIDTH; signed_in=0: zero-extend.
  - P = low 2*WIDTH bits of the product. This is exact, since |product| < 2^(2W).
- Result by op, when valid_out=1:
  - MUL_LO: out=P[WIDTH-1:0]. Accumulator unchanged.
  - MUL_HI: out=P[2W-1:W]. Accumulator unchanged.
  - MAC: sum = acc + ext(P), where ext is sign- or zero-extension to ACC_WIDTH per the stage's signed bit. out=sum[WIDTH-1:0]; acc <= sum at the closing edge.
  - MAC_CLR: sum = ext(P); out=sum[WIDTH-1:0]; acc <= sum; acc_ovf <= 0.
- out=0 whenever valid_out=0.
- acc_out always shows the accumulator register. It reflects a MAC result in the cycle after that MAC's valid_out.
- Back-to-back MACs: each reads the accumulator as updated by the previous valid cycle (no hazard).
- Overflow (MAC only):
  - signed: set if both addends have the same sign and sum's MSB differs;
  - unsigned: set on carry out of ACC_WIDTH.
  - acc_ovf is sticky. Only reset or MAC_CLR clears it. The accumulator wraps modulo 2^ACC_WIDTH.
- Reset mid-operation: all in-flight operations are dropped and produce no valid_out or accumulator update. The first operation accepted with rst_n=1 behaves normally.
- Reset asserted in the cycle a MAC reaches the final stage: the reset wins, and acc=0 afterwards.
- valid_in=0: the stage carries a bubble. Data stages may toggle, but valid_out stays 0 and the accumulator does not change.
- Synthesis maps the multiply onto one DSP slice for WIDTH<=18/27 operands, with the DSP's internal registers forming stages 1–2. The behavioural model above is normative.

Test Plan:
- Defaults, signed_in=0, MUL_LO, in0=0x1234, in1=0x0010 at edge 0 -> valid_out=1 two edges later, out=0x2340; acc_out stays 0.
- MUL_HI, signed_in=1, in0=0xFFFF (-1), in1=0x0002 -> out=0xFFFF. Same operands, signed_in=0 -> out=0x0001.
- MAC_CLR 3*4, then MAC 5*6, then MAC 0xFFFF*0xFFFF signed, on consecutive cycles -> out=12, 42, 43 on three consecutive valid cycles; acc_out=43 afterwards.
- ACC_WIDTH=32, WIDTH=16, unsigned: MAC_CLR 0xFFFF*0xFFFF, then MAC 0xFFFF*0xFFFF, then MAC 0x0003*0x0001 -> sum 0x1FFFC0002 wraps to acc=0xFFFC0002 and acc_ovf=1 after the second MAC; the third MAC gives acc=0xFFFC0005 with acc_ovf still 1. A following MAC_CLR 1*1 -> acc=1, acc_ovf=0.
- LATENCY=5, ops with valid_in pattern 1,0,1,1 -> valid_out pattern 1,0,1,1 starting five edges later; out=0 in the bubble cycle.
- Issue MAC 2*2 at edge 0 with acc=10, assert rst_n=0 at edge 1 for one cycle -> no valid_out ever appears for it; acc_out=0, acc_ovf=0. The next MAC 1*1 gives out=1.
